// File: rtl/alu_writeback.sv
// ALU writeback stage: evaluates the ARM condition field against the
// architectural NZCV register, updates the flags, and drives the single
// register-file write port. A long multiply (UMULL) is serialised into two
// write cycles (lo word first, hi word second); upstream is stalled with
// in_ready during the second cycle.
module alu_writeback #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        cond,
  input  logic [3:0]        alu_flags,
  input  logic [DATA_W-1:0] result,
  input  logic [DATA_W-1:0] result2,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rd_lo,
  input  logic              reg_write,
  input  logic              long_mul,
  input  logic [1:0]        flag_write,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [3:0]        flags,
  output logic              cond_ex
);

  typedef enum logic {
    IDLE = 1'b0,
    HI   = 1'b1
  } state_t;

  state_t            r_state;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [3:0]        r_flags;
  logic              r_cond_ex;
  logic [ADDR_W-1:0] r_hi_addr;
  logic [DATA_W-1:0] r_hi_data;

  logic              w_pass;
  logic [3:0]        w_flags_nxt;
  logic              w_n;
  logic              w_z;
  logic              w_c;
  logic              w_v;

  assign w_n = r_flags[3];
  assign w_z = r_flags[2];
  assign w_c = r_flags[1];
  assign w_v = r_flags[0];

  // Ready depends on state only, so there is no path from in_valid.
  assign in_ready = (r_state == IDLE);
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign flags    = r_flags;
  assign cond_ex  = r_cond_ex;

  // Condition-code evaluation against the architectural flags register.
  always_comb begin
    w_pass = 1'b0;
    case (cond)
      4'b0000: w_pass = w_z;
      4'b0001: w_pass = !w_z;
      4'b0010: w_pass = w_c;
      4'b0011: w_pass = !w_c;
      4'b0100: w_pass = w_n;
      4'b0101: w_pass = !w_n;
      4'b0110: w_pass = w_v;
      4'b0111: w_pass = !w_v;
      4'b1000: w_pass = w_c && !w_z;
      4'b1001: w_pass = !w_c || w_z;
      4'b1010: w_pass = (w_n == w_v);
      4'b1011: w_pass = (w_n != w_v);
      4'b1100: w_pass = !w_z && (w_n == w_v);
      4'b1101: w_pass = w_z || (w_n != w_v);
      4'b1110: w_pass = 1'b1;
      default: w_pass = 1'b0;
    endcase
  end

  // Next flags value for an accepted instruction; long multiplies never touch C,V.
  always_comb begin
    w_flags_nxt = r_flags;
    if (w_pass) begin
      if (long_mul) begin
        if (flag_write[1]) begin
          w_flags_nxt[3] = result[DATA_W-1];
          w_flags_nxt[2] = (result == '0) && (result2 == '0);
        end
      end else begin
        if (flag_write[1]) w_flags_nxt[3:2] = alu_flags[3:2];
        if (flag_write[0]) w_flags_nxt[1:0] = alu_flags[1:0];
      end
    end
  end

  // Writeback FSM: accept in IDLE, emit the held hi word in HI.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_flags   <= 4'b0000;
      r_cond_ex <= 1'b0;
      r_hi_addr <= '0;
      r_hi_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_cond_ex <= w_pass;
            r_flags   <= w_flags_nxt;
            if (w_pass && reg_write) begin
              r_wr_en <= 1'b1;
              if (long_mul) begin
                r_wr_addr <= rd_lo;
                r_wr_data <= result2;
                r_hi_addr <= rd;
                r_hi_data <= result;
                r_state   <= HI;
              end else begin
                r_wr_addr <= rd;
                r_wr_data <= result;
              end
            end else begin
              r_wr_en <= 1'b0;
            end
          end else begin
            r_wr_en <= 1'b0;
          end
        end
        HI: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_hi_addr;
          r_wr_data <= r_hi_data;
          r_state   <= IDLE;
        end
        default: begin
          r_wr_en <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Scoreboard bench for alu_writeback: the driver runs an architectural model
// at each accept and queues expected register writes; an independent monitor
// pops and compares whenever the DUT asserts wr_en, and tracks flags/cond_ex.
module tb_alu_writeback;

  typedef struct {
    logic [3:0]  cond;
    logic [1:0]  fw;
    logic [3:0]  alu;
    bit          rw;
    bit          lm;
    logic [3:0]  rd;
    logic [3:0]  rd_lo;
    logic [31:0] res;
    logic [31:0] res2;
  } txn_t;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  cond;
  logic [3:0]  alu_flags;
  logic [31:0] result;
  logic [31:0] result2;
  logic [3:0]  rd;
  logic [3:0]  rd_lo;
  logic        reg_write;
  logic        long_mul;
  logic [1:0]  flag_write;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  flags;
  logic        cond_ex;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  logic [3:0] m_flags   = 4'b0000;
  bit         m_cond_ex = 1'b0;
  bit         m_hi      = 1'b0;

  alu_writeback #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cond       (cond),
    .alu_flags  (alu_flags),
    .result     (result),
    .result2    (result2),
    .rd         (rd),
    .rd_lo      (rd_lo),
    .reg_write  (reg_write),
    .long_mul   (long_mul),
    .flag_write (flag_write),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .flags      (flags),
    .cond_ex    (cond_ex)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ARM condition semantics: cond[3:1] picks a predicate, cond[0] inverts it.
  function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cc, v, base;
    n = f[3]; z = f[2]; cc = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cc;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cc && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hE) return 1'b1;
    if (c == 4'hF) return 1'b0;
    return c[0] ? !base : base;
  endfunction

  function automatic txn_t mk(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] alu,
                              input bit rw, input bit lm, input logic [3:0] d, input logic [3:0] dlo,
                              input logic [31:0] r, input logic [31:0] r2);
    txn_t t;
    t.cond = c; t.fw = fw; t.alu = alu; t.rw = rw; t.lm = lm;
    t.rd = d; t.rd_lo = dlo; t.res = r; t.res2 = r2;
    return t;
  endfunction

  // Architectural effect of one accepted instruction.
  function automatic void model_accept(input txn_t t);
    exp_t e;
    bit   pass;
    pass      = cond_pass(t.cond, m_flags);
    m_cond_ex = pass;
    if (pass) begin
      if (t.lm) begin
        if (t.fw[1]) begin
          m_flags[3] = t.res[31];
          m_flags[2] = (t.res == 0) && (t.res2 == 0);
        end
      end else begin
        if (t.fw[1]) m_flags[3:2] = t.alu[3:2];
        if (t.fw[0]) m_flags[1:0] = t.alu[1:0];
      end
      if (t.rw) begin
        if (t.lm) begin
          e.addr = t.rd_lo; e.data = t.res2; q.push_back(e);
          e.addr = t.rd;    e.data = t.res;  q.push_back(e);
          m_hi = 1'b1;
        end else begin
          e.addr = t.rd; e.data = t.res; q.push_back(e);
        end
      end
    end
  endfunction

  task automatic drive(input txn_t t);
    cond = t.cond; flag_write = t.fw; alu_flags = t.alu; reg_write = t.rw;
    long_mul = t.lm; rd = t.rd; rd_lo = t.rd_lo; result = t.res; result2 = t.res2;
  endtask

  // Hold the instruction valid until the model says it is accepted.
  task automatic issue(input txn_t t);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 4 && !done; k++) begin
      @(negedge clk);
      drive(t);
      in_valid = 1'b1;
      chk("in_ready", 64'(in_ready), 64'(!m_hi));
      @(posedge clk);
      if (m_hi) m_hi = 1'b0;
      else begin
        model_accept(t);
        done = 1'b1;
      end
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got no accept expected accept");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      m_hi = 1'b0;
    end
  endtask

  // Monitor: compare every presented write against the scoreboard queue.
  always @(posedge clk) begin
    exp_t e;
    #1;
    chk("flags", 64'(flags), 64'(m_flags));
    chk("cond_ex", 64'(cond_ex), 64'(m_cond_ex));
    if (wr_en === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", wr_addr, wr_data);
      end else begin
        e = q.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(e.addr));
        chk("wr_data", 64'(wr_data), 64'(e.data));
      end
    end
  end

  initial begin
    txn_t t;
    reset = 1'b1; in_valid = 1'b0;
    drive(mk(4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0));
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_cond_ex", 64'(cond_ex), 64'd0);
    reset = 1'b0;

    // Simple AL write to r3.
    issue(mk(4'hE, 2'b00, 4'h0, 1'b1, 1'b0, 4'd3, 4'd0, 32'h5, 32'h0));
    #2;
    chk("add_wr_en", 64'(wr_en), 64'd1);
    chk("add_wr_addr", 64'(wr_addr), 64'd3);
    chk("add_wr_data", 64'(wr_data), 64'd5);
    idle(1);
    #2;
    chk("idle_wr_en", 64'(wr_en), 64'd0);
    chk("idle_flags", 64'(flags), 64'd0);

    // SUBS sets Z,C; EQ then passes, NE fails.
    issue(mk(4'hE, 2'b11, 4'b0110, 1'b0, 1'b0, 4'd0, 4'd0, 32'h0, 32'h0));
    issue(mk(4'h0, 2'b00, 4'h0, 1'b1, 1'b0, 4'd2, 4'd0, 32'h11, 32'h0));
    #2;
    chk("eq_flags", 64'(flags), 64'b0110);
    chk("eq_wr_en", 64'(wr_en), 64'd1);
    chk("eq_wr_data", 64'(wr_data), 64'h11);
    issue(mk(4'h1, 2'b00, 4'h0, 1'b1, 1'b0, 4'd2, 4'd0, 32'h22, 32'h0));
    #2;
    chk("ne_wr_en", 64'(wr_en), 64'd0);
    chk("ne_cond_ex", 64'(cond_ex), 64'd0);

    // UMULL followed immediately by an ADD held valid.
    issue(mk(4'hE, 2'b00, 4'h0, 1'b1, 1'b1, 4'd5, 4'd4, 32'h1, 32'hFFFF_FFFE));
    #2;
    chk("umull_lo_addr", 64'(wr_addr), 64'd4);
    chk("umull_lo_data", 64'(wr_data), 64'hFFFF_FFFE);
    chk("umull_in_ready", 64'(in_ready), 64'd0);
    issue(mk(4'hE, 2'b00, 4'h0, 1'b1, 1'b0, 4'd6, 4'd0, 32'h77, 32'h0));
    #2;
    chk("after_umull_addr", 64'(wr_addr), 64'd6);
    chk("after_umull_data", 64'(wr_data), 64'h77);

    // UMULLS with zero product keeps C,V.
    issue(mk(4'hE, 2'b11, 4'b0011, 1'b0, 1'b0, 4'd0, 4'd0, 32'h0, 32'h0));
    issue(mk(4'hE, 2'b11, 4'h0, 1'b1, 1'b1, 4'd7, 4'd8, 32'h0, 32'h0));
    #2;
    chk("umulls_flags", 64'(flags), 64'b0111);
    idle(2);

    // Reset while the hi word is pending.
    issue(mk(4'hE, 2'b00, 4'h0, 1'b1, 1'b1, 4'd9, 4'd10, 32'hAAAA, 32'hBBBB));
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    m_hi = 1'b0; m_flags = 4'b0000; m_cond_ex = 1'b0;
    if (q.size() > 0) void'(q.pop_back());
    #1;
    chk("hirst_wr_en", 64'(wr_en), 64'd0);
    chk("hirst_in_ready", 64'(in_ready), 64'd1);
    chk("hirst_flags", 64'(flags), 64'd0);
    chk("hirst_wr_addr", 64'(wr_addr), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    // Reserved condition never executes.
    issue(mk(4'hF, 2'b11, 4'b1111, 1'b1, 1'b0, 4'd1, 4'd0, 32'h99, 32'h0));
    #2;
    chk("nv_cond_ex", 64'(cond_ex), 64'd0);
    chk("nv_wr_en", 64'(wr_en), 64'd0);
    chk("nv_flags", 64'(flags), 64'd0);

    // Sweep every condition against every flag value.
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        issue(mk(4'hE, 2'b11, 4'(f), 1'b0, 1'b0, 4'd0, 4'd0, 32'h0, 32'h0));
        issue(mk(4'(c), 2'b00, 4'h0, 1'b1, 1'b0, 4'($urandom_range(0, 15)), 4'd0,
                 32'($urandom), 32'h0));
      end
    end

    // Randomised mix of normal and long instructions.
    for (int i = 0; i < 400; i++) begin
      t.cond  = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 15));
      t.lm    = ($urandom_range(0, 3) == 0);
      t.fw    = t.lm ? 2'b11 : 2'($urandom_range(0, 3));
      t.alu   = 4'($urandom_range(0, 15));
      t.rw    = ($urandom_range(0, 7) != 0);
      t.rd    = 4'($urandom_range(0, 15));
      t.rd_lo = ($urandom_range(0, 7) == 0) ? t.rd : 4'($urandom_range(0, 15));
      t.res   = ($urandom_range(0, 5) == 0) ? 32'h0 : 32'($urandom);
      t.res2  = ($urandom_range(0, 5) == 0) ? 32'h0 : 32'($urandom);
      issue(t);
      if ($urandom_range(0, 3) == 0) idle(1);
    end

    idle(3);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
